uart_mem_loader: RTL and testbench

Serial program loader for the on-board CPU's unified 64-bit memory. It receives 8N1 UART bytes on a board pin and packs eight bytes little-endian into one 64-bit word. Each completed word is written to the memory write port at consecutive addresses starting at 0. It is the write-side counterpart of the board top's memory read-out path, used to fill the memory that the CPU and LED display later read.

---
 rtl/uart_mem_loader.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Purpose  : Serial program loader for the CPU's unified 64-bit memory.
//            Receives 8N1 UART bytes, packs eight bytes little-endian into
//            one 64-bit word and writes each completed word to consecutive
//            memory addresses starting at 0, until the memory is full.
// Ports    : CLOCK_50   in   system clock, rising edge
//            reset      in   asynchronous active-high reset
//            rxd        in   UART receive line (idle high, asynchronous)
//            mem_we     out  one-cycle write strobe
//            mem_addr   out  write address, held until the next strobe
//            mem_wdata  out  write data, held until the next strobe
//            word_count out  words written since reset
//            load_done  out  sticky, last address has been written
//            frame_err  out  sticky, a bad stop bit has been seen
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int MEM_DEPTH = 3000,
  // word_count must be able to hold MEM_DEPTH itself once the memory is full
  parameter int ADDR_W    = 12
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              load_done,
  output logic              frame_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);

  // The bit counter already reads 1 on the first cycle of START (the
  // detecting cycle counts), so it equals the number of cycles elapsed
  // since the start edge appeared on the synchronized line.
  localparam logic [c_CNT_W-1:0] c_HALF_CNT  = c_CNT_W'(c_CLKS_PER_BIT / 2);
  localparam logic [c_CNT_W-1:0] c_FULL_M1   = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Input synchronizer; both stages reset to the idle (high) line level so
  // that reset release never looks like a start edge.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rxs;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rxs     <= r_rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_rx_byte;

  logic w_half_tick;
  logic w_full_tick;
  logic w_cnt_clr;
  logic w_bit_sample;
  logic w_stop_sample;

  assign w_half_tick = (r_clk_cnt == c_HALF_CNT);
  assign w_full_tick = (r_clk_cnt == c_FULL_M1);

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = c_ST_START;
        end
      end
      c_ST_START: begin
        // A start bit that is high again at mid-bit was a glitch
        if (w_half_tick) begin
          w_state_nxt = r_rxs ? c_ST_IDLE : c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_full_tick && (r_bit_idx == 3'd7)) begin
          w_state_nxt = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        // Leave at mid-stop-bit so an immediately following start bit is
        // still seen as a falling edge.
        if (w_full_tick) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    w_cnt_clr     = 1'b0;
    w_bit_sample  = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        // Counter stays at 0 while the line is idle and starts counting on
        // the cycle the start edge is detected.
        w_cnt_clr = r_rxs;
      end
      c_ST_START: begin
        w_cnt_clr = w_half_tick;
      end
      c_ST_DATA: begin
        if (w_full_tick) begin
          w_cnt_clr    = 1'b1;
          w_bit_sample = 1'b1;
        end
      end
      c_ST_STOP: begin
        if (w_full_tick) begin
          w_cnt_clr     = 1'b1;
          w_stop_sample = 1'b1;
        end
      end
      default: begin
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  // Bit-period counter, bit index and data shift register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_rx_byte <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end

      if (r_state != c_ST_DATA) begin
        r_bit_idx <= '0;
      end else if (w_bit_sample) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      // LSB arrives first, so shift in from the top
      if (w_bit_sample) begin
        r_rx_byte <= {r_rxs, r_rx_byte[7:1]};
      end
    end
  end

  logic w_byte_valid;
  logic w_byte_bad;

  assign w_byte_valid = w_stop_sample &  r_rxs;
  assign w_byte_bad   = w_stop_sample & ~r_rxs;

  // --------------------------------------------------------------------------
  // Word assembler and memory write port
  // --------------------------------------------------------------------------
  logic [2:0]        r_byte_idx;
  logic [55:0]       r_word;       // bytes 0..6; byte 7 goes straight out
  logic [ADDR_W-1:0] r_wr_addr;    // address of the next word to write
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [63:0]       r_mem_wdata;
  logic [ADDR_W-1:0] r_word_count;
  logic              r_load_done;
  logic              r_frame_err;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_wr_addr    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
      r_load_done  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;

      // A bad stop bit is flagged even once the memory is full
      if (w_byte_bad) begin
        r_frame_err <= 1'b1;
      end

      if (r_mem_we) begin
        // Bookkeeping for the word just written
        r_byte_idx   <= '0;
        r_word_count <= r_word_count + 1'b1;
        if (r_wr_addr == c_LAST_ADDR) begin
          r_load_done <= 1'b1;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end else if (w_byte_valid && !r_load_done) begin
        // Shift right so that after seven bytes byte 0 sits at [7:0]
        r_word <= {r_rx_byte, r_word[55:8]};
        if (r_byte_idx == 3'd7) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_wr_addr;
          r_mem_wdata <= {r_rx_byte, r_word};
        end else begin
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign word_count = r_word_count;
  assign load_done  = r_load_done;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Purpose  : Self-checking bench for uart_mem_loader. A small instance
//            (16 clocks per bit, 4-word memory) covers the functional cases;
//            a default-parameter instance runs concurrently with off-rate
//            baud stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

  localparam int  c_CPB   = 16;
  localparam int  c_DEPTH = 4;
  localparam int  c_AW    = 3;
  localparam int  c_AW_D  = 12;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Small instance
  logic              reset_s, rxd_s;
  logic              mem_we_s, load_done_s, frame_err_s;
  logic [c_AW-1:0]   mem_addr_s, word_count_s;
  logic [63:0]       mem_wdata_s;

  uart_mem_loader #(.CLK_HZ(16), .BAUD(1), .MEM_DEPTH(c_DEPTH), .ADDR_W(c_AW)) u_dut_s (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset_s),
    .rxd        (rxd_s),
    .mem_we     (mem_we_s),
    .mem_addr   (mem_addr_s),
    .mem_wdata  (mem_wdata_s),
    .word_count (word_count_s),
    .load_done  (load_done_s),
    .frame_err  (frame_err_s)
  );

  // Default-parameter instance
  logic              reset_d, rxd_d;
  logic              mem_we_d, load_done_d, frame_err_d;
  logic [c_AW_D-1:0] mem_addr_d, word_count_d;
  logic [63:0]       mem_wdata_d;

  uart_mem_loader u_dut_d (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset_d),
    .rxd        (rxd_d),
    .mem_we     (mem_we_d),
    .mem_addr   (mem_addr_d),
    .mem_wdata  (mem_wdata_d),
    .word_count (word_count_d),
    .load_done  (load_done_d),
    .frame_err  (frame_err_d)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Write monitors (sample on the falling edge)
  // --------------------------------------------------------------------------
  logic [c_AW-1:0]   obs_addr_q[$];
  logic [63:0]       obs_data_q[$];
  int                obs_cyc_q[$];
  int                done_rise_cyc = -1;
  logic              prev_we_s = 1'b0;
  logic              prev_done_s = 1'b0;

  logic [c_AW_D-1:0] obs_d_addr_q[$];
  logic [63:0]       obs_d_data_q[$];

  always @(negedge CLOCK_50) begin
    if (mem_we_s) begin
      obs_addr_q.push_back(mem_addr_s);
      obs_data_q.push_back(mem_wdata_s);
      obs_cyc_q.push_back(cyc);
      check_eq("we_width_s", 64'(prev_we_s), 64'(0));
    end
    if (load_done_s && !prev_done_s) done_rise_cyc = cyc;
    prev_we_s   = mem_we_s;
    prev_done_s = load_done_s;
    if (mem_we_d) begin
      obs_d_addr_q.push_back(mem_addr_d);
      obs_d_data_q.push_back(mem_wdata_d);
    end
  end

  // --------------------------------------------------------------------------
  // Reference model for the small instance: a byte stream in, a list of
  // (address, word) writes out.
  // --------------------------------------------------------------------------
  logic [7:0]      part_q[$];
  logic [c_AW-1:0] exp_addr_q[$];
  logic [63:0]     exp_data_q[$];
  int              m_count = 0;
  bit              m_done  = 1'b0;
  bit              m_ferr  = 1'b0;

  task automatic model_reset();
    part_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    obs_addr_q.delete();
    obs_data_q.delete();
    obs_cyc_q.delete();
    m_count = 0;
    m_done  = 1'b0;
    m_ferr  = 1'b0;
    done_rise_cyc = -1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [63:0] w;
    if (!ok) begin
      m_ferr = 1'b1;
    end else if (!m_done) begin
      part_q.push_back(b);
      if (part_q.size() == 8) begin
        w = '0;
        for (int i = 0; i < 8; i++) w = w | (64'(part_q[i]) << (8 * i));
        exp_addr_q.push_back(c_AW'(m_count));
        exp_data_q.push_back(w);
        m_count++;
        if (m_count == c_DEPTH) m_done = 1'b1;
        part_q.delete();
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_eq({tag, "_nwr"}, 64'(obs_addr_q.size()), 64'(exp_addr_q.size()));
    n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, 64'(obs_addr_q[i]), 64'(exp_addr_q[i]));
      check_eq({tag, "_data"}, obs_data_q[i], exp_data_q[i]);
    end
    check_eq({tag, "_wcnt"}, 64'(word_count_s), 64'(m_count));
    check_eq({tag, "_done"}, 64'(load_done_s), 64'(m_done));
    check_eq({tag, "_ferr"}, 64'(frame_err_s), 64'(m_ferr));
    if (exp_addr_q.size() > 0) begin
      check_eq({tag, "_addr_hold"}, 64'(mem_addr_s), 64'(exp_addr_q[exp_addr_q.size()-1]));
      check_eq({tag, "_data_hold"}, mem_wdata_s, exp_data_q[exp_data_q.size()-1]);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers (small instance tasks are entered at a falling edge)
  // --------------------------------------------------------------------------
  int last_start_cyc = 0;

  task automatic send_byte_s(input logic [7:0] b, input bit ok);
    rxd_s = 1'b0;
    last_start_cyc = cyc;
    repeat (c_CPB) @(negedge CLOCK_50);
    for (int i = 0; i < 8; i++) begin
      rxd_s = b[i];
      repeat (c_CPB) @(negedge CLOCK_50);
    end
    rxd_s = ok;
    repeat (c_CPB) @(negedge CLOCK_50);
    model_byte(b, ok);
  endtask

  task automatic reset_s_pulse();
    reset_s = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset_s = 1'b0;
    model_reset();
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic send_byte_d(input logic [7:0] b, input real bit_ns);
    rxd_d = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd_d = b[i];
      #(bit_ns);
    end
    rxd_d = 1'b1;
    #(bit_ns);
  endtask

  task automatic send_word_d(input logic [63:0] w, input real bit_ns);
    for (int i = 0; i < 8; i++) send_byte_d(w[8*i +: 8], bit_ns);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    reset_s = 1'b1;
    reset_d = 1'b1;
    rxd_s   = 1'b1;
    rxd_d   = 1'b1;
    fork
      begin : small_run
        @(negedge CLOCK_50);
        check_eq("rst_we",    64'(mem_we_s),     64'(0));
        check_eq("rst_addr",  64'(mem_addr_s),   64'(0));
        check_eq("rst_wdata", mem_wdata_s,       64'(0));
        check_eq("rst_wcnt",  64'(word_count_s), 64'(0));
        check_eq("rst_done",  64'(load_done_s),  64'(0));
        check_eq("rst_ferr",  64'(frame_err_s),  64'(0));
        repeat (2) @(negedge CLOCK_50);
        reset_s = 1'b0;
        model_reset();
        repeat (4) @(negedge CLOCK_50);

        // Single word 0x01..0x08, plus write latency from the last start edge
        for (int i = 1; i <= 8; i++) send_byte_s(8'(i), 1'b1);
        repeat (3 * c_CPB) @(negedge CLOCK_50);
        compare_writes("single");
        check_eq("single_value", (obs_data_q.size() > 0) ? obs_data_q[0] : 64'hX,
                 64'h0807060504030201);
        if (obs_cyc_q.size() > 0)
          check_eq("single_latency", 64'(obs_cyc_q[0] - last_start_cyc),
                   64'(c_CPB / 2 + 9 * c_CPB + 3));

        // Glitch rejection followed by a random word
        reset_s_pulse();
        rxd_s = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        rxd_s = 1'b1;
        repeat (3 * c_CPB) @(negedge CLOCK_50);
        compare_writes("glitch");
        for (int i = 0; i < 8; i++) send_byte_s(8'($urandom_range(0, 255)), 1'b1);
        repeat (3 * c_CPB) @(negedge CLOCK_50);
        compare_writes("glitch_word");

        // Framing error then 0x11..0x88
        reset_s_pulse();
        send_byte_s(8'($urandom_range(0, 255)), 1'b0);
        rxd_s = 1'b1;
        repeat (2 * c_CPB) @(negedge CLOCK_50);
        for (int i = 1; i <= 8; i++) send_byte_s(8'(i * 17), 1'b1);
        repeat (3 * c_CPB) @(negedge CLOCK_50);
        compare_writes("framing");
        check_eq("framing_value", (obs_data_q.size() > 0) ? obs_data_q[0] : 64'hX,
                 64'h8877665544332211);

        // Fill to full: 5 words back-to-back
        reset_s_pulse();
        for (int i = 0; i < 40; i++) send_byte_s(8'($urandom_range(0, 255)), 1'b1);
        repeat (3 * c_CPB) @(negedge CLOCK_50);
        if (obs_cyc_q.size() >= 4)
          check_eq("done_timing", 64'(done_rise_cyc), 64'(obs_cyc_q[3] + 1));
        else
          check_eq("done_timing_nwr", 64'(obs_cyc_q.size()), 64'(4));
        compare_writes("fill");

        // Reset mid-word
        reset_s_pulse();
        send_byte_s(8'($urandom_range(0, 255)), 1'b0);
        rxd_s = 1'b1;
        repeat (2 * c_CPB) @(negedge CLOCK_50);
        for (int i = 0; i < 12; i++) send_byte_s(8'($urandom_range(0, 255)), 1'b1);
        compare_writes("pre_reset");
        rxd_s = 1'b0;
        repeat (c_CPB) @(negedge CLOCK_50);
        rxd_s = 1'b1;
        repeat (c_CPB + c_CPB / 2) @(negedge CLOCK_50);
        reset_s = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_eq("midrst_we",    64'(mem_we_s),     64'(0));
        check_eq("midrst_addr",  64'(mem_addr_s),   64'(0));
        check_eq("midrst_wdata", mem_wdata_s,       64'(0));
        check_eq("midrst_wcnt",  64'(word_count_s), 64'(0));
        check_eq("midrst_done",  64'(load_done_s),  64'(0));
        check_eq("midrst_ferr",  64'(frame_err_s),  64'(0));
        reset_s = 1'b0;
        model_reset();
        repeat (2 * c_CPB) @(negedge CLOCK_50);
        for (int i = 0; i < 8; i++) send_byte_s(8'(8'hA0 + i), 1'b1);
        repeat (3 * c_CPB) @(negedge CLOCK_50);
        compare_writes("after_rst");
        check_eq("after_rst_value", (obs_data_q.size() > 0) ? obs_data_q[0] : 64'hX,
                 64'hA7A6A5A4A3A2A1A0);
      end

      begin : default_run
        logic [63:0] w0;
        logic [63:0] w1;
        w0 = {32'($urandom()), 32'($urandom())};
        w1 = {32'($urandom()), 32'($urandom())};
        repeat (3) @(negedge CLOCK_50);
        reset_d = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        send_word_d(w0, 1.0e9 / 113000.0);
        send_word_d(w1, 1.0e9 / 117000.0);
        repeat (50) @(negedge CLOCK_50);
        check_eq("dflt_nwr", 64'(obs_d_addr_q.size()), 64'(2));
        if (obs_d_addr_q.size() >= 2) begin
          check_eq("dflt_addr0", 64'(obs_d_addr_q[0]), 64'(0));
          check_eq("dflt_data0", obs_d_data_q[0], w0);
          check_eq("dflt_addr1", 64'(obs_d_addr_q[1]), 64'(1));
          check_eq("dflt_data1", obs_d_data_q[1], w1);
        end
        check_eq("dflt_wcnt", 64'(word_count_d), 64'(2));
        check_eq("dflt_ferr", 64'(frame_err_d),  64'(0));
        check_eq("dflt_done", 64'(load_done_d),  64'(0));
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
